// File: rtl/dpll_pkg.sv
// Shared types for the DPLL gain scheduler: state encoding and the
// per-state proportional/integral gain table.
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        LOCK  = 2'd3
    } state_t;

    localparam int GAIN_TBL_W = 16;

    localparam int unsigned DEF_P_ACQ  = 500;
    localparam int unsigned DEF_I_ACQ  = 100;
    localparam int unsigned DEF_P_TRK  = 125;
    localparam int unsigned DEF_I_TRK  = 25;
    localparam int unsigned DEF_P_FINE = 31;
    localparam int unsigned DEF_I_FINE = 6;

    typedef struct packed {
        logic [GAIN_TBL_W-1:0] p;
        logic [GAIN_TBL_W-1:0] i;
    } gain_pair_t;

    typedef struct packed {
        logic [GAIN_TBL_W-1:0] p_acq;
        logic [GAIN_TBL_W-1:0] i_acq;
        logic [GAIN_TBL_W-1:0] p_trk;
        logic [GAIN_TBL_W-1:0] i_trk;
        logic [GAIN_TBL_W-1:0] p_fine;
        logic [GAIN_TBL_W-1:0] i_fine;
    } gain_table_t;

    // IDLE shares the acquisition gains so IDLE<->ACQ never changes the filter.
    function automatic gain_pair_t gain_of(input state_t s, input gain_table_t t);
        gain_pair_t g;
        case (s)
            TRACK:   begin g.p = t.p_trk;  g.i = t.i_trk;  end
            LOCK:    begin g.p = t.p_fine; g.i = t.i_fine; end
            default: begin g.p = t.p_acq;  g.i = t.i_acq;  end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/toggle_window_counter.sv
// Counts phase_error toggles over fixed windows of WIN_LEN cycles and
// presents the window total in the last cycle of each window.
module toggle_window_counter #(
    parameter int WIN_LEN = 64,
    parameter int TOG_W   = $clog2(WIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phase_error,
    input  logic             clear,
    output logic             win_end,
    output logic [TOG_W-1:0] tog_total
);

    localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int SUM_W = TOG_W + 1;

    logic             prev_pe;
    logic [WIN_W-1:0] win_cnt;
    logic [TOG_W-1:0] tog_cnt;
    logic             toggle;
    logic [SUM_W-1:0] tog_sum;

    assign toggle  = phase_error ^ prev_pe;
    assign tog_sum = {1'b0, tog_cnt} + {{TOG_W{1'b0}}, toggle};

    // Includes the current cycle's toggle so the window-end total is complete.
    assign tog_total = (tog_sum > SUM_W'(WIN_LEN)) ? TOG_W'(WIN_LEN) : tog_sum[TOG_W-1:0];
    assign win_end   = (win_cnt == WIN_W'(WIN_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pe <= 1'b0;
            win_cnt <= '0;
            tog_cnt <= '0;
        end else begin
            prev_pe <= phase_error;
            if (clear || win_end) begin
                win_cnt <= '0;
                tog_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                tog_cnt <= tog_total;
            end
        end
    end

endmodule

// File: rtl/loop_gain_scheduler.sv
// DPLL loop-filter gain scheduler: steps gains ACQ -> TRACK -> LOCK on toggle-rate
// lock metric. Optional macro GAIN_OVERRIDE_EN adds ovr_en/ovr_p/ovr_i gain override.
module loop_gain_scheduler
    import dpll_pkg::*;
#(
    parameter int          GAIN_W         = GAIN_TBL_W,
    parameter int          WIN_LEN        = 64,
    parameter int          LOCK_TOGGLES   = 24,
    parameter int          UNLOCK_TOGGLES = 8,
    parameter int          LOCK_WINDOWS   = 4,
    parameter int          SETTLE         = 32,
    parameter int unsigned P_ACQ          = DEF_P_ACQ,
    parameter int unsigned I_ACQ          = DEF_I_ACQ,
    parameter int unsigned P_TRK          = DEF_P_TRK,
    parameter int unsigned I_TRK          = DEF_I_TRK,
    parameter int unsigned P_FINE         = DEF_P_FINE,
    parameter int unsigned I_FINE         = DEF_I_FINE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              phase_error,
`ifdef GAIN_OVERRIDE_EN
    input  logic              ovr_en,
    input  logic [GAIN_W-1:0] ovr_p,
    input  logic [GAIN_W-1:0] ovr_i,
`endif
    output logic [GAIN_W-1:0] p_gain,
    output logic [GAIN_W-1:0] i_gain,
    output logic              gain_update,
    output logic              locked,
    output logic [1:0]        state
);

    localparam int TOG_W  = $clog2(WIN_LEN + 1);
    localparam int GOOD_W = (LOCK_WINDOWS > 1) ? $clog2(LOCK_WINDOWS + 1) : 1;
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    localparam gain_table_t GAINS = '{
        p_acq:  GAIN_TBL_W'(P_ACQ),
        i_acq:  GAIN_TBL_W'(I_ACQ),
        p_trk:  GAIN_TBL_W'(P_TRK),
        i_trk:  GAIN_TBL_W'(I_TRK),
        p_fine: GAIN_TBL_W'(P_FINE),
        i_fine: GAIN_TBL_W'(I_FINE)
    };

    state_t              state_q;
    state_t              state_next;
    logic                state_changed;
    logic [SET_W-1:0]    settle_cnt;
    logic [SET_W-1:0]    settle_next;
    logic                settling;
    logic [GOOD_W-1:0]   good_cnt;
    logic [GOOD_W-1:0]   good_next;
    logic [GOOD_W-1:0]   good_inc;
    logic                clear_cnt;
    logic                win_end;
    logic [TOG_W-1:0]    tog_total;
    logic                window_eval;
    logic                window_good;
    logic                lock_lost;
    gain_pair_t          tbl_next;
    logic [GAIN_W-1:0]   p_next;
    logic [GAIN_W-1:0]   i_next;
    logic                upd_next;

    toggle_window_counter #(
        .WIN_LEN (WIN_LEN),
        .TOG_W   (TOG_W)
    ) u_win (
        .clk         (clk),
        .rst         (rst),
        .phase_error (phase_error),
        .clear       (clear_cnt),
        .win_end     (win_end),
        .tog_total   (tog_total)
    );

    assign settling    = (settle_cnt != '0);
    assign window_eval = win_end && !settling && (state_q != IDLE);
    assign window_good = (tog_total >= TOG_W'(LOCK_TOGGLES));
    assign lock_lost   = (tog_total <  TOG_W'(UNLOCK_TOGGLES));
    assign good_inc    = good_cnt + GOOD_W'(1);

    always_comb begin
        state_next = state_q;
        good_next  = good_cnt;
        case (state_q)
            IDLE: begin
                if (enable) state_next = ACQ;
            end
            ACQ, TRACK: begin
                if (window_eval) begin
                    // Loss of lock outranks the advance rule.
                    if (state_q == TRACK && lock_lost) begin
                        state_next = ACQ;
                    end else if (window_good) begin
                        if (good_inc == GOOD_W'(LOCK_WINDOWS))
                            state_next = (state_q == ACQ) ? TRACK : LOCK;
                        else
                            good_next = good_inc;
                    end else begin
                        good_next = '0;
                    end
                end
            end
            LOCK: begin
                if (window_eval && lock_lost) state_next = ACQ;
            end
            default: state_next = IDLE;
        endcase

        if (!enable) state_next = IDLE;

        state_changed = (state_next != state_q);
        if (state_changed || state_next == IDLE) good_next = '0;

        if (state_next == IDLE)
            settle_next = '0;
        else if (state_changed)
            settle_next = SET_W'(SETTLE);
        else if (settling)
            settle_next = settle_cnt - SET_W'(1);
        else
            settle_next = settle_cnt;

        // The window restarts from zero once the settle period has elapsed.
        clear_cnt = settling || state_changed || (state_next == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_cnt <= '0;
            good_cnt   <= '0;
        end else begin
            state_q    <= state_next;
            settle_cnt <= settle_next;
            good_cnt   <= good_next;
        end
    end

`ifdef GAIN_OVERRIDE_EN
    logic ovr_en_q;

    always_comb begin
        tbl_next = gain_of(state_next, GAINS);
        p_next   = ovr_en ? ovr_p : GAIN_W'(tbl_next.p);
        i_next   = ovr_en ? ovr_i : GAIN_W'(tbl_next.i);
        upd_next = (ovr_en != ovr_en_q) || (p_next != p_gain) || (i_next != i_gain);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovr_en_q <= 1'b0;
        else     ovr_en_q <= ovr_en;
    end
`else
    always_comb begin
        tbl_next = gain_of(state_next, GAINS);
        p_next   = GAIN_W'(tbl_next.p);
        i_next   = GAIN_W'(tbl_next.i);
        upd_next = (p_next != p_gain) || (i_next != i_gain);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_gain      <= GAIN_W'(P_ACQ);
            i_gain      <= GAIN_W'(I_ACQ);
            gain_update <= 1'b0;
        end else begin
            p_gain      <= p_next;
            i_gain      <= i_next;
            gain_update <= upd_next;
        end
    end

    assign locked = (state_q == LOCK);
    assign state  = state_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Bench for loop_gain_scheduler: directed scenarios plus randomized phase_error,
// each cycle compared against a window/age-based reference model.
module tb_loop_gain_scheduler;

    localparam int WIN_LEN        = 64;
    localparam int LOCK_TOGGLES   = 24;
    localparam int UNLOCK_TOGGLES = 8;
    localparam int LOCK_WINDOWS   = 4;
    localparam int SETTLE         = 32;
    localparam int S_IDLE = 0, S_ACQ = 1, S_TRK = 2, S_LOCK = 3;
    localparam int EXP_W  = 36;
`ifdef GAIN_OVERRIDE_EN
    localparam bit HAS_OVR = 1'b1;
`else
    localparam bit HAS_OVR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        phase_error = 1'b0;
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_p = '0;
    logic [15:0] ovr_i = '0;
    logic [15:0] p_gain;
    logic [15:0] i_gain;
    logic        gain_update;
    logic        locked;
    logic [1:0]  state;

    loop_gain_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .phase_error (phase_error),
`ifdef GAIN_OVERRIDE_EN
        .ovr_en      (ovr_en),
        .ovr_p       (ovr_p),
        .ovr_i       (ovr_i),
`endif
        .p_gain      (p_gain),
        .i_gain      (i_gain),
        .gain_update (gain_update),
        .locked      (locked),
        .state       (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q[$];

    // reference model state
    int m_state, m_age, m_tog, m_good, m_p, m_i;
    bit m_prev_pe, m_ovr_q;

    // per-phase observations
    int cyc, obs_pulses, first_trk, first_lock;
    logic cur_pe;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int tbl_p(input int s);
        case (s)
            S_TRK:   return 125;
            S_LOCK:  return 31;
            default: return 500;
        endcase
    endfunction

    function automatic int tbl_i(input int s);
        case (s)
            S_TRK:   return 25;
            S_LOCK:  return 6;
            default: return 100;
        endcase
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_age = 0; m_tog = 0; m_good = 0;
        m_prev_pe = 1'b0; m_ovr_q = 1'b0; m_p = 500; m_i = 100;
        exp_q.delete();
    endtask

    // Window position inside the current state, or -1 while idle/settling.
    function automatic int win_pos();
        if (m_state == S_IDLE || m_age < SETTLE) return -1;
        return (m_age - SETTLE) % WIN_LEN;
    endfunction

    function automatic int win_idx();
        if (m_state == S_IDLE || m_age < SETTLE) return -1;
        return (m_age - SETTLE) / WIN_LEN;
    endfunction

    task automatic model_step(input logic en, input logic pe, input logic oe,
                              input logic [15:0] op, input logic [15:0] oi);
        int nxt, good_new, total, pos, p_new, i_new, old_age;
        bit tog, wend, upd, use_ovr;
        logic [1:0]  st_v;
        logic [15:0] p_v, i_v;
        tog = (pe != m_prev_pe);
        wend = 1'b0; total = 0; nxt = m_state; good_new = m_good; old_age = m_age;
        if (m_state != S_IDLE && m_age >= SETTLE) begin
            pos   = (m_age - SETTLE) % WIN_LEN;
            wend  = (pos == WIN_LEN - 1);
            total = m_tog + int'(tog);
        end
        if (m_state == S_IDLE) begin
            if (en) nxt = S_ACQ;
        end else if (wend) begin
            if (m_state != S_ACQ && total < UNLOCK_TOGGLES) nxt = S_ACQ;
            else if (m_state != S_LOCK) begin
                good_new = (total >= LOCK_TOGGLES) ? m_good + 1 : 0;
                if (good_new == LOCK_WINDOWS) nxt = m_state + 1;
            end
        end
        if (!en) nxt = S_IDLE;
        if (nxt != m_state || nxt == S_IDLE) begin
            m_age = 0; m_tog = 0; m_good = 0;
        end else begin
            m_good = good_new;
            if (old_age >= SETTLE) m_tog = wend ? 0 : m_tog + int'(tog);
            m_age = old_age + 1;
        end
        use_ovr = HAS_OVR && oe;
        p_new = use_ovr ? int'(op) : tbl_p(nxt);
        i_new = use_ovr ? int'(oi) : tbl_i(nxt);
        upd = (p_new != m_p) || (i_new != m_i) || (HAS_OVR && (oe != m_ovr_q));
        m_state = nxt; m_p = p_new; m_i = i_new; m_prev_pe = pe; m_ovr_q = HAS_OVR && oe;
        st_v = nxt[1:0]; p_v = p_new[15:0]; i_v = i_new[15:0];
        exp_q.push_back({st_v, p_v, i_v, upd, (nxt == S_LOCK)});
    endtask

    task automatic phase_reset();
        cyc = 0; obs_pulses = 0; first_trk = -1; first_lock = -1;
    endtask

    // driver: apply inputs, advance one edge, compare against the model
    task automatic drive_cycle(input logic en, input logic pe);
        logic [EXP_W-1:0] exp_v, got_v;
        enable = en; phase_error = pe;
        model_step(en, pe, ovr_en, ovr_p, ovr_i);
        @(posedge clk); #1;
        cyc++;
        exp_v = exp_q.pop_front();
        got_v = {state, p_gain, i_gain, gain_update, locked};
        check_val("outputs", got_v, exp_v);
        if (gain_update) obs_pulses++;
        if (state == 2'd2 && first_trk < 0)  first_trk  = cyc;
        if (state == 2'd3 && first_lock < 0) first_lock = cyc;
    endtask

    task automatic run_alternating(input int n);
        for (int k = 0; k < n; k++) begin
            cur_pe = ~cur_pe;
            drive_cycle(1'b1, cur_pe);
        end
    endtask

    initial begin
        bit found;
        int pos, target;
        int dens;
        logic en_r;
        model_reset();
        cur_pe = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_state",  state, 0);
        check_val("rst_p",      p_gain, 500);
        check_val("rst_i",      i_gain, 100);
        check_val("rst_upd",    gain_update, 0);
        check_val("rst_locked", locked, 0);
        rst = 1'b0;

        // acquisition through to lock with a toggle every cycle
        phase_reset();
        run_alternating(600);
        check_val("acq_to_trk_cycle", first_trk, 289);
        check_val("trk_to_lock_cycle", first_lock, 577);
        check_val("lock_pulses", obs_pulses, 2);
        check_val("lock_p", p_gain, 31);
        check_val("lock_i", i_gain, 6);
        check_val("lock_flag", locked, 1);

        // constant phase_error in LOCK: loss of lock
        phase_reset();
        cur_pe = 1'b1;
        for (int k = 0; k < 120; k++) drive_cycle(1'b1, cur_pe);
        check_val("unlock_state", state, S_ACQ);
        check_val("unlock_locked", locked, 0);
        check_val("unlock_p", p_gain, 500);
        check_val("unlock_i", i_gain, 100);
        check_val("unlock_pulses", obs_pulses, 1);

        // ACQ with windows alternating 30 / 10 toggles never advances
        phase_reset();
        for (int k = 0; k < 2000; k++) begin
            pos = win_pos();
            if (pos >= 0) begin
                target = (win_idx() % 2 == 0) ? 30 : 10;
                if (pos < target) cur_pe = ~cur_pe;
            end
            drive_cycle(1'b1, cur_pe);
        end
        check_val("acq_no_track", (first_trk < 0), 1);
        check_val("acq_hold_state", state, S_ACQ);

        // reach TRACK, then drop enable on a full-toggle window end
        phase_reset();
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            cur_pe = ~cur_pe;
            drive_cycle(1'b1, cur_pe);
            if (m_state == S_TRK) begin found = 1'b1; break; end
        end
        check_val("reach_track", found, 1);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            cur_pe = ~cur_pe;
            if (win_pos() == WIN_LEN - 1) begin
                drive_cycle(1'b0, cur_pe);
                found = 1'b1;
                break;
            end
            drive_cycle(1'b1, cur_pe);
        end
        check_val("trk_win_end_found", found, 1);
        check_val("disable_state", state, S_IDLE);
        check_val("disable_p", p_gain, 500);
        check_val("disable_i", i_gain, 100);
        check_val("disable_upd", gain_update, 1);

        // back to LOCK from a fresh enable
        phase_reset();
        run_alternating(600);
        check_val("relock_cycle", first_lock, 577);

`ifdef GAIN_OVERRIDE_EN
        ovr_en = 1'b1; ovr_p = 16'd7; ovr_i = 16'd3;
        run_alternating(1);
        check_val("ovr_p", p_gain, 7);
        check_val("ovr_i", i_gain, 3);
        check_val("ovr_upd", gain_update, 1);
        run_alternating(3);
        check_val("ovr_steady_upd", gain_update, 0);
        ovr_p = 16'd9;
        run_alternating(1);
        check_val("ovr_change_upd", gain_update, 1);
        ovr_en = 1'b0;
        run_alternating(1);
        check_val("ovr_exit_p", p_gain, 31);
        check_val("ovr_exit_i", i_gain, 6);
        check_val("ovr_exit_upd", gain_update, 1);
        check_val("ovr_state", state, S_LOCK);
`endif

        // asynchronous reset in the middle of a LOCK window
        run_alternating(20);
        check_val("pre_rst_locked", locked, 1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_p", p_gain, 500);
        check_val("arst_i", i_gain, 100);
        check_val("arst_upd", gain_update, 0);
        check_val("arst_locked", locked, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // randomized toggle density and occasional enable drops
        phase_reset();
        dens = 80;
        for (int k = 0; k < 4000; k++) begin
            if (k % WIN_LEN == 0)
                dens = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(40, 100);
            if ($urandom_range(0, 99) < dens) cur_pe = ~cur_pe;
            en_r = ($urandom_range(0, 799) != 0);
            drive_cycle(en_r, cur_pe);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
